reflet_timer_irq_sched: RTL and testbench
=========================================

# reflet_timer_irq_sched

Interrupt scheduler sitting between up to eight `reflet_timer_2` instances and the CPU's single timer interrupt input. Latches each timer's one-cycle `interrupt` pulse into a pending bit, masks it, grants one pending source at a time with round-robin fairness, and holds the CPU interrupt high until software acknowledges. Memory-mapped on the 8-bit system bus, four registers, same access style as the other peripherals.

## Interface
- `base_addr_size`, 16, width of `addr`
- `base_addr`, 16'hFF15, address of register 0; block occupies `base_addr` .. `base_addr+3`
- `nb_sources`, 4, number of timer sources, legal range 1..8

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears every register and state
- `enable`  in  1  bus access qualifier
- `addr`  in  `base_addr_size`  bus address
- `write_en`  in  1  bus write strobe, one write per cycle while high
- `data_in`  in  8  bus write data
- `data_out`  out  8  read data; 0 when not addressed
- `timer_irq`  in  `nb_sources`  one-cycle pulses from timers; bit i = source i
- `interrupt`  out  1  level interrupt to CPU

## Operation
- Selected when `enable && base_addr <= addr < base_addr+4`; offset = `addr - base_addr` (2 bits).
- Offset 0 PENDING: read pending bits; write 1 clears bit (W1C). Bits >= `nb_sources` read 0.
- Offset 1 MASK: R/W, bit i = 1 enables source i. Reset 0.
- Offset 2 CURRENT: read {valid, 4'b0, index[2:0]}; valid = 1 only in SERVE. Any write while in SERVE = acknowledge; ignored otherwise.
- Offset 3 OVERRUN: bit i set when source i pulses while its pending bit is already 1; W1C.
- Pending set by `timer_irq[i]`; set wins over same-cycle W1C on that bit (bit stays 1, no overrun flagged).
- FSM, 2-bit state:
  - IDLE: if `pending & mask` != 0, arbiter picks winner, latch into `cur_idx`, go SERVE.
  - SERVE: `interrupt` = 1. On acknowledge: clear `pending[cur_idx]`, round-robin pointer = `cur_idx+1` (wraps to 0 past `nb_sources-1`), go GAP. If `pending[cur_idx]` or `mask[cur_idx]` drops to 0 (software W1C / mask write), go GAP without pointer update.
  - GAP: `interrupt` = 0 for exactly one cycle, guarantees a CPU-visible edge between grants; go IDLE.
- Round-robin: lowest index >= pointer among `pending & mask`, else lowest index overall. Pointer reset 0.
- Acknowledge and a new pulse on `cur_idx` in same cycle: pending stays 1 (set wins), source re-eligible after GAP.

## Timing
- `interrupt` decoded directly from state register: high exactly in SERVE cycles.
- Pulse at cycle t (source unmasked, FSM in IDLE): pending = 1 at t+1, SERVE and `interrupt` = 1 at t+2.
- Ack write at cycle a: `interrupt` = 0 at a+1 (GAP), IDLE at a+2, next SERVE earliest a+3.
- `data_out` combinational from `addr` and current register state; writes take effect next edge.
- Reset values: `interrupt` 0, `data_out` 0 when unaddressed, PENDING/MASK/OVERRUN 0, pointer 0, state IDLE. Reset mid-SERVE drops `interrupt` asynchronously.

## Structure
- Shared header `reflet_timer_irq_sched_defs.vh`: register offsets (0..3), state encodings IDLE/SERVE/GAP, CURRENT valid bit position.
- Sub-module `reflet_rr_arbiter`: parameterised width, inputs request vector and pointer, outputs one-hot grant and binary index, purely combinational.

## Test plan
- Mask=0x01, pulse source 0 at t -> `interrupt` high at t+2, CURRENT reads 0x80; write CURRENT -> low next cycle, PENDING = 0.
- Mask=0x0F, pulse sources 1 and 3 same cycle, pointer 0 -> grant 1, ack, GAP, grant 3, ack; pointer ends 0 (wrap past 3).
- Mask=0x00, pulse source 2 -> PENDING=0x04, `interrupt` stays 0; write MASK=0x04 -> `interrupt` high two cycles later.
- Source 0 pending, pulse again -> OVERRUN=0x01; W1C OVERRUN with simultaneous pulse on source 0 while pending stays 1 -> OVERRUN reads 0x01 after.
- In SERVE on source 2, write MASK=0x00 -> GAP, IDLE, `interrupt` 0, pointer unchanged, PENDING still 0x04.
- Assert `reset` low mid-SERVE, asynchronous to `clk` -> `interrupt` 0 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/reflet_timer_irq_sched_pkg.sv
// Shared definitions for the timer interrupt scheduler:
// register offsets, FSM encodings and CURRENT field layout.
package reflet_timer_irq_sched_pkg;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_MASK    = 2'd1;
    localparam logic [1:0] OFF_CURRENT = 2'd2;
    localparam logic [1:0] OFF_OVERRUN = 2'd3;

    localparam int CUR_VALID_BIT = 7;
    localparam int IDX_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/reflet_rr_arbiter.sv
// Combinational round-robin arbiter: lowest request at or above
// the pointer wins, otherwise the lowest request overall.
module reflet_rr_arbiter #(
    parameter int width = 4
) (
    input  logic [width-1:0] req,
    input  logic [2:0]       ptr,
    output logic [width-1:0] grant,
    output logic [2:0]       index
);

    always_comb begin
        index = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (req[i]) index = 3'(i);
        end
        // second pass overrides with the first hit at or above ptr
        for (int i = width - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) index = 3'(i);
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < width; i++) begin
            grant[i] = req[i] && (index == 3'(i));
        end
    end

endmodule

// File: rtl/reflet_timer_irq_sched.sv
// Timer interrupt scheduler: latches timer pulses, masks them and
// grants one source at a time to the CPU until software acks it.
module reflet_timer_irq_sched #(
    parameter int base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr = 16'hFF15,
    parameter int nb_sources = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic [nb_sources-1:0]     timer_irq,
    output logic                      interrupt
);

    import reflet_timer_irq_sched_pkg::*;

    state_t state, state_nxt;

    logic [base_addr_size-1:0] diff;
    logic                      sel;
    logic                      wr;
    logic [1:0]                off;

    logic [nb_sources-1:0] pending;
    logic [nb_sources-1:0] mask;
    logic [nb_sources-1:0] ovr;
    logic [nb_sources-1:0] pend_clr;
    logic [nb_sources-1:0] ovr_clr;
    logic [nb_sources-1:0] cur_hot;
    logic [nb_sources-1:0] grant;
    logic [IDX_W-1:0]      cur_idx;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      win_idx;
    logic                  ack;
    logic                  src_lost;
    logic                  unused_data;

    assign diff = addr - base_addr;
    assign sel  = enable && (addr >= base_addr)
               && (diff < base_addr_size'(4));
    assign off  = diff[1:0];
    assign wr   = sel && write_en;
    assign ack  = wr && (off == OFF_CURRENT) && (state == ST_SERVE);

    assign unused_data = ^data_in;

    reflet_rr_arbiter #(
        .width(nb_sources)
    ) u_arb (
        .req  (pending & mask),
        .ptr  (ptr),
        .grant(grant),
        .index(win_idx)
    );

    always_comb begin
        pend_clr = '0;
        ovr_clr  = '0;
        cur_hot  = '0;
        for (int i = 0; i < nb_sources; i++) begin
            cur_hot[i]  = (cur_idx == IDX_W'(i));
            pend_clr[i] = (wr && (off == OFF_PENDING) && data_in[i])
                       || (ack && cur_hot[i]);
            ovr_clr[i]  = wr && (off == OFF_OVERRUN) && data_in[i];
        end
    end

    assign src_lost = ~|(pending & mask & cur_hot);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (|grant) state_nxt = ST_SERVE;
            ST_SERVE: if (ack || src_lost) state_nxt = ST_GAP;
            ST_GAP:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        interrupt = (state == ST_SERVE);
    end

    // a new pulse always beats a same-cycle clear and then flags no overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            mask    <= '0;
            ovr     <= '0;
            cur_idx <= '0;
            ptr     <= '0;
        end else begin
            pending <= timer_irq | (pending & ~pend_clr);
            ovr     <= (timer_irq & pending & ~pend_clr) | (ovr & ~ovr_clr);
            if (wr && (off == OFF_MASK)) mask <= data_in[nb_sources-1:0];
            if ((state == ST_IDLE) && |grant) cur_idx <= win_idx;
            if (ack) begin
                ptr <= (cur_idx == IDX_W'(nb_sources - 1))
                     ? '0 : cur_idx + 1'b1;
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (sel) begin
            unique case (off)
                OFF_PENDING: data_out = 8'(pending);
                OFF_MASK:    data_out = 8'(mask);
                OFF_CURRENT: begin
                    data_out[CUR_VALID_BIT] = (state == ST_SERVE);
                    data_out[IDX_W-1:0]     = cur_idx;
                end
                OFF_OVERRUN: data_out = 8'(ovr);
                default:     data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_timer_irq_sched.sv
// Directed bench for reflet_timer_irq_sched with hand-computed
// expected register and interrupt values.
module tb_reflet_timer_irq_sched;

    localparam logic [15:0] BASE = 16'hFF15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] addr = '0;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic [3:0]  timer_irq = '0;
    logic        interrupt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reflet_timer_irq_sched #(
        .base_addr_size(16),
        .base_addr     (BASE),
        .nb_sources    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .addr     (addr),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .timer_irq(timer_irq),
        .interrupt(interrupt)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] off, input logic [7:0] d);
        enable   = 1'b1;
        write_en = 1'b1;
        addr     = BASE + 16'(off);
        data_in  = d;
        tick();
        enable   = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        data_in  = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] off,
                           input logic [7:0] exp);
        enable   = 1'b1;
        write_en = 1'b0;
        addr     = BASE + 16'(off);
        #1;
        check(tag, data_out, exp);
        enable = 1'b0;
        addr   = '0;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {7'b0, interrupt}, {7'b0, exp});
    endtask

    task automatic pulse(input logic [3:0] v);
        timer_irq = v;
        tick();
        timer_irq = '0;
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk_irq("rst_irq", 1'b0);
        chk_reg("rst_pend", 2'd0, 8'h00);
        chk_reg("rst_mask", 2'd1, 8'h00);
        chk_reg("rst_cur", 2'd2, 8'h00);
        chk_reg("rst_ovr", 2'd3, 8'h00);

        // single source: latency and ack
        bus_wr(2'd1, 8'h01);
        chk_reg("mask_rd", 2'd1, 8'h01);
        pulse(4'b0001);
        chk_irq("t1_irq", 1'b0);
        chk_reg("t1_pend", 2'd0, 8'h01);
        tick();
        chk_irq("t2_irq", 1'b1);
        chk_reg("t2_cur", 2'd2, 8'h80);
        bus_wr(2'd2, 8'h00);
        chk_irq("ack_irq", 1'b0);
        chk_reg("ack_pend", 2'd0, 8'h00);
        chk_reg("gap_cur", 2'd2, 8'h00);
        tick();

        // two sources, round robin and wrap
        bus_wr(2'd1, 8'h0F);
        pulse(4'b1010);
        tick();
        chk_irq("rr1_irq", 1'b1);
        chk_reg("rr1_cur", 2'd2, 8'h81);
        bus_wr(2'd2, 8'h00);
        chk_irq("rr_gap", 1'b0);
        tick();
        chk_irq("rr_idle", 1'b0);
        tick();
        chk_irq("rr3_irq", 1'b1);
        chk_reg("rr3_cur", 2'd2, 8'h83);
        bus_wr(2'd2, 8'h00);
        chk_reg("rr_pend", 2'd0, 8'h00);
        tick();

        // masked source stays pending
        bus_wr(2'd1, 8'h00);
        pulse(4'b0100);
        tick();
        tick();
        chk_irq("msk_irq", 1'b0);
        chk_reg("msk_pend", 2'd0, 8'h04);
        enable = 1'b1;
        addr = BASE + 16'd4;
        #1 check("unaddr_hi", data_out, 8'h00);
        addr = BASE - 16'd1;
        #1 check("unaddr_lo", data_out, 8'h00);
        enable = 1'b0;
        addr = BASE;
        #1 check("unaddr_en", data_out, 8'h00);
        addr = '0;
        bus_wr(2'd1, 8'h04);
        chk_irq("unmsk_w1", 1'b0);
        tick();
        chk_irq("unmsk_w2", 1'b1);
        chk_reg("unmsk_cur", 2'd2, 8'h82);

        // mask drop during SERVE
        bus_wr(2'd1, 8'h00);
        tick();
        tick();
        chk_irq("drop_irq", 1'b0);
        chk_reg("drop_pend", 2'd0, 8'h04);
        chk_reg("drop_cur", 2'd2, 8'h02);

        // pointer must still be 0: 2 wins over 3
        pulse(4'b1000);
        bus_wr(2'd1, 8'h0C);
        tick();
        chk_reg("ptr_cur", 2'd2, 8'h82);
        bus_wr(2'd2, 8'h00);
        tick();
        tick();
        chk_reg("ptr_next", 2'd2, 8'h83);
        bus_wr(2'd2, 8'h00);
        tick();

        // overrun and set-wins behaviour
        bus_wr(2'd1, 8'h00);
        pulse(4'b0001);
        pulse(4'b0001);
        chk_reg("ovr_set", 2'd3, 8'h01);
        chk_reg("ovr_pend", 2'd0, 8'h01);
        timer_irq = 4'b0001;
        bus_wr(2'd3, 8'h01);
        timer_irq = '0;
        chk_reg("ovr_keep", 2'd3, 8'h01);
        bus_wr(2'd3, 8'h01);
        chk_reg("ovr_clr", 2'd3, 8'h00);
        timer_irq = 4'b0001;
        bus_wr(2'd0, 8'h01);
        timer_irq = '0;
        chk_reg("pw1c_set", 2'd0, 8'h01);
        chk_reg("pw1c_ovr", 2'd3, 8'h00);
        bus_wr(2'd0, 8'h01);
        chk_reg("pw1c_clr", 2'd0, 8'h00);

        // asynchronous reset mid-SERVE
        bus_wr(2'd1, 8'h01);
        pulse(4'b0001);
        tick();
        chk_irq("pre_rst", 1'b1);
        #2 reset = 1'b0;
        #1 chk_irq("async_rst", 1'b0);
        tick();
        #3 reset = 1'b1;
        chk_reg("post_pend", 2'd0, 8'h00);
        chk_reg("post_mask", 2'd1, 8'h00);
        chk_reg("post_cur", 2'd2, 8'h00);
        chk_reg("post_ovr", 2'd3, 8'h00);
        tick();
        chk_irq("post_irq", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
